// File: rtl/decode_packet.sv
// ---------------------------------------------------------------------------
// decode_packet
//   USB 2.0 receive-side packet decoder. Consumes the ULPI Rx byte stream
//   (PID first) and decodes token, handshake and data packets:
//     - tokens: ADDR/ENDP extraction plus CRC5 residual check
//     - handshakes: type reported with a 1-cycle pulse
//     - data: payload forwarded with the two CRC16 bytes stripped, CRC16 and
//       length status reported at end of packet
//   All outputs are registered; end-of-packet pulses appear one cycle after
//   the last byte is accepted.
//
// Handshake semantics: a byte is transferred on every clock where
// rx_tvalid_i is high (rx_tready_o is tied high, the USB receiver cannot be
// stalled). rx_tlast_i is only looked at together with rx_tvalid_i. The
// payload output has no back-pressure: the sink takes every cycle where
// out_tvalid_o is high.
//
// Ports
//   clock, reset         60 MHz clock, synchronous active-high reset
//   rx_tvalid_i/_tready_o/_tlast_i/_tdata_i   Rx byte stream in
//   tok_recv_o, tok_type_o, tok_addr_o, tok_endp_o   decoded token
//   hsk_recv_o, hsk_type_o                           decoded handshake
//   out_start_o, out_type_o                          DATAx PID accepted
//   out_tvalid_o, out_tlast_o, out_tdata_o           payload stream out
//   dat_done_o, dat_crc_ok_o                         data packet status
//   rx_err_o                                         framing / CRC5 error
//   dbg_state_o                                      current FSM state
// ---------------------------------------------------------------------------
module decode_packet #(
    parameter int MAX_LENGTH = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_tvalid_i,
    output logic       rx_tready_o,
    input  logic       rx_tlast_i,
    input  logic [7:0] rx_tdata_i,
    output logic       tok_recv_o,
    output logic [1:0] tok_type_o,
    output logic [6:0] tok_addr_o,
    output logic [3:0] tok_endp_o,
    output logic       hsk_recv_o,
    output logic [1:0] hsk_type_o,
    output logic       out_start_o,
    output logic [1:0] out_type_o,
    output logic       out_tvalid_o,
    output logic       out_tlast_o,
    output logic [7:0] out_tdata_o,
    output logic       dat_done_o,
    output logic       dat_crc_ok_o,
    output logic       rx_err_o,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TOK1 = 3'd1,
        ST_TOK2 = 3'd2,
        ST_DATA = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    localparam logic [10:0] LP_MAX = 11'(MAX_LENGTH);
    localparam logic [10:0] LP_SAT = 11'(MAX_LENGTH + 1);

    // CRC5 shift register (x^5 + x^2 + 1), init all ones, bits LSB first.
    // Running it over the 11 data bits plus the transmitted CRC field leaves
    // the fixed residual 5'b01100 on a good token.
    function automatic logic [4:0] crc5_16(input logic [15:0] d);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            fb = d[i] ^ c[4];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'h05;
        end
        return c;
    endfunction

    // CRC16 (x^16 + x^15 + x^2 + 1), one byte, bits LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = d[i] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    state_t      r_state,      w_state_nxt;
    logic [1:0]  r_pid_type,   w_pid_type_nxt;
    logic [7:0]  r_tok1,       w_tok1_nxt;
    logic [7:0]  r_dly0,       w_dly0_nxt;     // oldest byte in the delay line
    logic [7:0]  r_dly1,       w_dly1_nxt;
    logic [1:0]  r_fill,       w_fill_nxt;     // bytes held in the delay line
    logic [10:0] r_cnt,        w_cnt_nxt;      // payload bytes shifted out
    logic [15:0] r_crc,        w_crc_nxt;
    logic        r_tok_recv,   w_tok_recv_nxt;
    logic [1:0]  r_tok_type,   w_tok_type_nxt;
    logic [6:0]  r_tok_addr,   w_tok_addr_nxt;
    logic [3:0]  r_tok_endp,   w_tok_endp_nxt;
    logic        r_hsk_recv,   w_hsk_recv_nxt;
    logic [1:0]  r_hsk_type,   w_hsk_type_nxt;
    logic        r_out_start,  w_out_start_nxt;
    logic [1:0]  r_out_type,   w_out_type_nxt;
    logic        r_out_tvalid, w_out_tvalid_nxt;
    logic        r_out_tlast,  w_out_tlast_nxt;
    logic [7:0]  r_out_tdata,  w_out_tdata_nxt;
    logic        r_dat_done,   w_dat_done_nxt;
    logic        r_dat_ok,     w_dat_ok_nxt;
    logic        r_rx_err,     w_rx_err_nxt;

    logic        w_pid_ok;
    logic [4:0]  w_tok_res;
    logic [15:0] w_crc_emit;
    logic        w_can_fwd;
    logic [10:0] w_cnt_inc;
    logic        w_zlp_ok;
    logic        w_end_ok;

    assign w_pid_ok   = (rx_tdata_i[7:4] == ~rx_tdata_i[3:0]);
    assign w_tok_res  = crc5_16({rx_tdata_i, r_tok1});
    // CRC including the byte that leaves the delay line this cycle.
    assign w_crc_emit = crc16_byte(r_crc, r_dly0);
    assign w_can_fwd  = (r_cnt < LP_MAX);
    assign w_cnt_inc  = (r_cnt == LP_SAT) ? r_cnt : r_cnt + 11'd1;
    // The CRC field goes out low byte first, so the current byte is the high half.
    assign w_zlp_ok   = ({rx_tdata_i, r_dly0} == ~bitrev16(r_crc));
    assign w_end_ok   = ({rx_tdata_i, r_dly1} == ~bitrev16(w_crc_emit));

    always_comb begin
        w_state_nxt      = r_state;
        w_pid_type_nxt   = r_pid_type;
        w_tok1_nxt       = r_tok1;
        w_dly0_nxt       = r_dly0;
        w_dly1_nxt       = r_dly1;
        w_fill_nxt       = r_fill;
        w_cnt_nxt        = r_cnt;
        w_crc_nxt        = r_crc;
        w_tok_recv_nxt   = 1'b0;
        w_tok_type_nxt   = r_tok_type;
        w_tok_addr_nxt   = r_tok_addr;
        w_tok_endp_nxt   = r_tok_endp;
        w_hsk_recv_nxt   = 1'b0;
        w_hsk_type_nxt   = r_hsk_type;
        w_out_start_nxt  = 1'b0;
        w_out_type_nxt   = r_out_type;
        w_out_tvalid_nxt = 1'b0;
        w_out_tlast_nxt  = 1'b0;
        w_out_tdata_nxt  = r_out_tdata;
        w_dat_done_nxt   = 1'b0;
        w_dat_ok_nxt     = 1'b0;
        w_rx_err_nxt     = 1'b0;

        if (rx_tvalid_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_pid_ok) begin
                        w_rx_err_nxt = 1'b1;
                        if (!rx_tlast_i) w_state_nxt = ST_DROP;
                    end else begin
                        case (rx_tdata_i[1:0])
                            2'b01: begin
                                if (rx_tlast_i) begin
                                    w_rx_err_nxt = 1'b1;
                                end else begin
                                    w_pid_type_nxt = rx_tdata_i[3:2];
                                    w_state_nxt    = ST_TOK1;
                                end
                            end
                            2'b10: begin
                                if (rx_tlast_i) begin
                                    w_hsk_recv_nxt = 1'b1;
                                    w_hsk_type_nxt = rx_tdata_i[3:2];
                                end else begin
                                    w_state_nxt = ST_DROP;
                                end
                            end
                            2'b11: begin
                                w_out_start_nxt = 1'b1;
                                w_out_type_nxt  = rx_tdata_i[3:2];
                                w_crc_nxt       = 16'hFFFF;
                                w_fill_nxt      = 2'd0;
                                w_cnt_nxt       = 11'd0;
                                if (rx_tlast_i) begin
                                    w_dat_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_DATA;
                                end
                            end
                            default: begin
                                // PING/SPLIT/PRE/reserved are not handled here.
                                if (!rx_tlast_i) w_state_nxt = ST_DROP;
                            end
                        endcase
                    end
                end
                ST_TOK1: begin
                    w_tok1_nxt = rx_tdata_i;
                    if (rx_tlast_i) begin
                        w_rx_err_nxt = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_TOK2;
                    end
                end
                ST_TOK2: begin
                    if (rx_tlast_i) begin
                        w_state_nxt = ST_IDLE;
                        if (w_tok_res == 5'b01100) begin
                            w_tok_recv_nxt = 1'b1;
                            w_tok_type_nxt = r_pid_type;
                            w_tok_addr_nxt = r_tok1[6:0];
                            w_tok_endp_nxt = {rx_tdata_i[2:0], r_tok1[7]};
                        end else begin
                            w_rx_err_nxt = 1'b1;
                        end
                    end else begin
                        w_rx_err_nxt = 1'b1;
                        w_state_nxt  = ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (r_fill != 2'd2) begin
                        if (r_fill == 2'd0) w_dly0_nxt = rx_tdata_i;
                        else                w_dly1_nxt = rx_tdata_i;
                        w_fill_nxt = r_fill + 2'd1;
                    end else begin
                        // Once the length limit is hit the byte still moves
                        // through the line (and CRC) but is not forwarded.
                        if (w_can_fwd) begin
                            w_out_tvalid_nxt = 1'b1;
                            w_out_tdata_nxt  = r_dly0;
                            w_out_tlast_nxt  = rx_tlast_i;
                        end
                        w_crc_nxt  = w_crc_emit;
                        w_cnt_nxt  = w_cnt_inc;
                        w_dly0_nxt = r_dly1;
                        w_dly1_nxt = rx_tdata_i;
                    end
                    if (rx_tlast_i) begin
                        w_state_nxt    = ST_IDLE;
                        w_dat_done_nxt = 1'b1;
                        case (r_fill)
                            2'd1:    w_dat_ok_nxt = w_zlp_ok;
                            2'd2:    w_dat_ok_nxt = w_end_ok && (w_cnt_inc <= LP_MAX);
                            default: w_dat_ok_nxt = 1'b0;
                        endcase
                    end
                end
                ST_DROP: begin
                    if (rx_tlast_i) w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pid_type   <= 2'd0;
            r_tok1       <= 8'd0;
            r_dly0       <= 8'd0;
            r_dly1       <= 8'd0;
            r_fill       <= 2'd0;
            r_cnt        <= 11'd0;
            r_crc        <= 16'hFFFF;
            r_tok_recv   <= 1'b0;
            r_tok_type   <= 2'd0;
            r_tok_addr   <= 7'd0;
            r_tok_endp   <= 4'd0;
            r_hsk_recv   <= 1'b0;
            r_hsk_type   <= 2'd0;
            r_out_start  <= 1'b0;
            r_out_type   <= 2'd0;
            r_out_tvalid <= 1'b0;
            r_out_tlast  <= 1'b0;
            r_out_tdata  <= 8'd0;
            r_dat_done   <= 1'b0;
            r_dat_ok     <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pid_type   <= w_pid_type_nxt;
            r_tok1       <= w_tok1_nxt;
            r_dly0       <= w_dly0_nxt;
            r_dly1       <= w_dly1_nxt;
            r_fill       <= w_fill_nxt;
            r_cnt        <= w_cnt_nxt;
            r_crc        <= w_crc_nxt;
            r_tok_recv   <= w_tok_recv_nxt;
            r_tok_type   <= w_tok_type_nxt;
            r_tok_addr   <= w_tok_addr_nxt;
            r_tok_endp   <= w_tok_endp_nxt;
            r_hsk_recv   <= w_hsk_recv_nxt;
            r_hsk_type   <= w_hsk_type_nxt;
            r_out_start  <= w_out_start_nxt;
            r_out_type   <= w_out_type_nxt;
            r_out_tvalid <= w_out_tvalid_nxt;
            r_out_tlast  <= w_out_tlast_nxt;
            r_out_tdata  <= w_out_tdata_nxt;
            r_dat_done   <= w_dat_done_nxt;
            r_dat_ok     <= w_dat_ok_nxt;
            r_rx_err     <= w_rx_err_nxt;
        end
    end

    assign rx_tready_o  = 1'b1;
    assign tok_recv_o   = r_tok_recv;
    assign tok_type_o   = r_tok_type;
    assign tok_addr_o   = r_tok_addr;
    assign tok_endp_o   = r_tok_endp;
    assign hsk_recv_o   = r_hsk_recv;
    assign hsk_type_o   = r_hsk_type;
    assign out_start_o  = r_out_start;
    assign out_type_o   = r_out_type;
    assign out_tvalid_o = r_out_tvalid;
    assign out_tlast_o  = r_out_tlast;
    assign out_tdata_o  = r_out_tdata;
    assign dat_done_o   = r_dat_done;
    assign dat_crc_ok_o = r_dat_ok;
    assign rx_err_o     = r_rx_err;
    assign dbg_state_o  = r_state;

endmodule
